// File: rtl/fir_feeder_if.sv
// fir_feeder_if
// Groups every non-clock, non-reset signal of fir_feeder into one bundle.
//   master : environment side (config host, upstream sample source, filter)
//   slave  : the fir_feeder block
// Signals:
//   coeff_wr/coeff_addr/coeff_wdata : coefficient bank write port
//   cfg_start                       : request to download the bank to the filter
//   in_valid/in_data/in_ready       : upstream sample handshake
//   modwait                         : filter busy
//   sample_data/data_ready          : sample and its strobe to the filter
//   fir_coefficient/load_coeff      : coefficient and its strobe to the filter
//   fifo_count/overflow/coeff_ok    : status
interface fir_feeder_if;
  logic        coeff_wr;
  logic [1:0]  coeff_addr;
  logic [15:0] coeff_wdata;
  logic        cfg_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        modwait;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic        data_ready;
  logic        load_coeff;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        coeff_ok;

  modport master (
    output coeff_wr, coeff_addr, coeff_wdata, cfg_start,
           in_valid, in_data, modwait,
    input  in_ready, sample_data, fir_coefficient, data_ready,
           load_coeff, fifo_count, overflow, coeff_ok
  );

  modport slave (
    input  coeff_wr, coeff_addr, coeff_wdata, cfg_start,
           in_valid, in_data, modwait,
    output in_ready, sample_data, fir_coefficient, data_ready,
           load_coeff, fifo_count, overflow, coeff_ok
  );
endinterface

// File: rtl/fir_feeder.sv
// fir_feeder
// Buffers upstream samples in an 8-deep FIFO and feeds them, one at a time,
// to a FIR filter that signals busy through modwait. On cfg_start (accepted
// only while idle) the 4-entry coefficient bank is downloaded to the filter
// first, one coefficient per load_coeff strobe. Samples are only sent once a
// complete bank has been downloaded since reset.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : fir_feeder_if.slave (see the interface for the signal list)
// All outputs toward the filter and the status outputs come straight from
// flops; the FSM computes their next values.
module fir_feeder (
  input  logic        clk,
  input  logic        rst,
  fir_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLOAD = 3'd1,
    ST_CWAIT = 3'd2,
    ST_SEND  = 3'd3,
    ST_SWAIT = 3'd4
  } state_t;

  // FSM state
  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  idx_r;
  logic [1:0]  idx_nxt_s;
  logic        send_cnt_r;
  logic        send_cnt_nxt_s;
  logic        cfg_done_s;
  logic        pop_s;

  // coefficient bank and sample FIFO
  logic [15:0] bank_r [4];
  logic [15:0] fifo_mem_r [8];
  logic [2:0]  wr_ptr_r;
  logic [2:0]  rd_ptr_r;
  logic [3:0]  count_r;
  logic [3:0]  count_nxt_s;
  logic        in_ready_r;
  logic        overflow_r;
  logic        push_s;
  logic        drop_s;

  // registered outputs and their next values
  logic [15:0] sample_data_r;
  logic [15:0] sample_nxt_s;
  logic [15:0] fir_coefficient_r;
  logic [15:0] coef_nxt_s;
  logic        data_ready_r;
  logic        data_ready_nxt_s;
  logic        load_coeff_r;
  logic        load_coeff_nxt_s;
  logic        coeff_ok_r;
  logic        coeff_ok_nxt_s;

  // in_ready is a pure function of the current occupancy, so a pop in the
  // same cycle never opens the door for an extra push.
  assign push_s = bus.in_valid && in_ready_r;
  assign drop_s = bus.in_valid && !in_ready_r;

  // The FIFO head is taken on the cycle the FSM leaves IDLE for SEND, so the
  // sample is already in sample_data when data_ready first rises.
  assign pop_s = (state_r == ST_IDLE) && (state_nxt_s == ST_SEND);

  // FSM state register with bank index and SEND-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 2'd0;
      send_cnt_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      send_cnt_r <= send_cnt_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    send_cnt_nxt_s = send_cnt_r;
    cfg_done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // a download request wins over pending samples
        if (bus.cfg_start) begin
          state_nxt_s = ST_CLOAD;
          idx_nxt_s   = 2'd0;
        end else if (coeff_ok_r && (count_r != 4'd0)) begin
          state_nxt_s    = ST_SEND;
          send_cnt_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLOAD: begin
        state_nxt_s = ST_CWAIT;
      end
      ST_CWAIT: begin
        if (!bus.modwait) begin
          if (idx_r == 2'd3) begin
            state_nxt_s = ST_IDLE;
            cfg_done_s  = 1'b1;
          end else begin
            state_nxt_s = ST_CLOAD;
            idx_nxt_s   = idx_r + 2'd1;
          end
        end else begin
          state_nxt_s = ST_CWAIT;
        end
      end
      ST_SEND: begin
        // data_ready stays up for exactly two cycles
        if (send_cnt_r) begin
          state_nxt_s = ST_SWAIT;
        end else begin
          state_nxt_s    = ST_SEND;
          send_cnt_nxt_s = 1'b1;
        end
      end
      ST_SWAIT: begin
        if (!bus.modwait) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SWAIT;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        idx_nxt_s      = 2'd0;
        send_cnt_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM output logic: next values of the registered filter-side outputs
  always_comb begin
    load_coeff_nxt_s = (state_nxt_s == ST_CLOAD);
    data_ready_nxt_s = (state_nxt_s == ST_SEND);
    if (state_nxt_s == ST_CLOAD) begin
      coef_nxt_s = bank_r[idx_nxt_s];
    end else begin
      coef_nxt_s = fir_coefficient_r;
    end
    if (pop_s) begin
      sample_nxt_s = fifo_mem_r[rd_ptr_r];
    end else begin
      sample_nxt_s = sample_data_r;
    end
    if (cfg_done_s) begin
      coeff_ok_nxt_s = 1'b1;
    end else begin
      coeff_ok_nxt_s = coeff_ok_r;
    end
  end

  // Registered filter-side and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      load_coeff_r      <= 1'b0;
      data_ready_r      <= 1'b0;
      fir_coefficient_r <= 16'd0;
      sample_data_r     <= 16'd0;
      coeff_ok_r        <= 1'b0;
    end else begin
      load_coeff_r      <= load_coeff_nxt_s;
      data_ready_r      <= data_ready_nxt_s;
      fir_coefficient_r <= coef_nxt_s;
      sample_data_r     <= sample_nxt_s;
      coeff_ok_r        <= coeff_ok_nxt_s;
    end
  end

  // Coefficient bank: writable only while idle so a download in progress
  // always sees a consistent bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        bank_r[i] <= 16'd0;
      end
    end else if (bus.coeff_wr && (state_r == ST_IDLE)) begin
      bank_r[bus.coeff_addr] <= bus.coeff_wdata;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        fifo_mem_r[i] <= 16'd0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // FIFO occupancy after this cycle's push/pop; both together cancel out
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 4'd1;
      2'b01:   count_nxt_s = count_r - 4'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers (3-bit, wrap modulo 8), occupancy, in_ready, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= 3'd0;
      rd_ptr_r   <= 3'd0;
      count_r    <= 4'd0;
      in_ready_r <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 3'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 3'd1;
      end
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s < 4'd8);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.sample_data     = sample_data_r;
  assign bus.fir_coefficient = fir_coefficient_r;
  assign bus.data_ready      = data_ready_r;
  assign bus.load_coeff      = load_coeff_r;
  assign bus.fifo_count      = count_r;
  assign bus.overflow        = overflow_r;
  assign bus.coeff_ok        = coeff_ok_r;

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder
// Drives fir_feeder with directed and randomized traffic and compares every
// cycle against a queue-based reference model: accepted samples are queued
// in arrival order, each data_ready pulse must deliver the queue head, each
// load_coeff pulse must carry the next bank entry, and occupancy, in_ready,
// overflow and the held output values must track the model.
// A small filter model raises modwait for busy_len cycles after each strobe.
module tb_fir_feeder;
  logic clk = 1'b0;
  logic rst;

  fir_feeder_if bus ();

  fir_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;

  // reference model
  logic [15:0] m_bank [4];
  logic [15:0] q [$];
  logic        m_ovf;
  logic [15:0] m_coef;
  logic [15:0] m_sample;
  int          m_load_idx;
  int          m_loads;
  int          n_sends;
  logic        wr_ignored;
  logic [15:0] loaded [$];

  // protocol tracking and filter model
  logic        prev_dr;
  logic        prev_lc;
  int          dr_len;
  int          lc_len;
  logic        mw_low_seen;
  int          busy;
  int          busy_len;
  logic        hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 16'd0;
    q.delete();
    m_ovf       = 1'b0;
    m_coef      = 16'd0;
    m_sample    = 16'd0;
    m_load_idx  = 0;
    m_loads     = 0;
    prev_dr     = 1'b0;
    prev_lc     = 1'b0;
    dr_len      = 0;
    lc_len      = 0;
    mw_low_seen = 1'b1;
    busy        = 0;
  endtask

  // one clock: capture applied inputs, step the edge, update model, check
  task automatic tick();
    logic        c_rst, c_valid, c_wr, c_mw;
    logic [15:0] c_data, c_wdata;
    logic [1:0]  c_addr;
    logic        dr_rise, lc_rise;
    int          pre_size;
    c_rst   = rst;
    c_valid = bus.in_valid;
    c_data  = bus.in_data;
    c_wr    = bus.coeff_wr;
    c_addr  = bus.coeff_addr;
    c_wdata = bus.coeff_wdata;
    c_mw    = bus.modwait;
    @(posedge clk);
    #1;
    if (c_rst) begin
      model_reset();
      check_eq("rst_dr", 32'(bus.data_ready), 32'd0);
      check_eq("rst_lc", 32'(bus.load_coeff), 32'd0);
      check_eq("rst_cok", 32'(bus.coeff_ok), 32'd0);
    end else begin
      dr_rise  = bus.data_ready && !prev_dr;
      lc_rise  = bus.load_coeff && !prev_lc;
      pre_size = q.size();
      if (!c_mw) mw_low_seen = 1'b1;
      if (dr_rise) begin
        n_sends++;
        check_eq("send_needs_bank", 32'(m_loads >= 4), 32'd1);
        check_eq("send_after_idle", 32'(mw_low_seen), 32'd1);
        check_eq("send_nonempty", 32'(pre_size != 0), 32'd1);
        if (pre_size != 0) m_sample = q.pop_front();
        mw_low_seen = 1'b0;
      end
      if (c_valid) begin
        if (pre_size < 8) q.push_back(c_data);
        else m_ovf = 1'b1;
      end
      if (lc_rise) begin
        m_coef     = m_bank[m_load_idx];
        m_load_idx = (m_load_idx + 1) % 4;
        m_loads++;
        loaded.push_back(bus.fir_coefficient);
        mw_low_seen = 1'b0;
      end
      if (c_wr && !wr_ignored) m_bank[c_addr] = c_wdata;
      // pulse widths
      if (bus.data_ready) dr_len++;
      else begin
        if (prev_dr) check_eq("dr_width", 32'(dr_len), 32'd2);
        dr_len = 0;
      end
      if (bus.load_coeff) lc_len++;
      else begin
        if (prev_lc) check_eq("lc_width", 32'(lc_len), 32'd1);
        lc_len = 0;
      end
      prev_dr = bus.data_ready;
      prev_lc = bus.load_coeff;
      if (dr_rise || lc_rise) busy = busy_len;
      else if (busy > 0) busy--;
      if (m_loads < 4) check_eq("coeff_ok_early", 32'(bus.coeff_ok), 32'd0);
    end
    check_eq("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 8));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("sample_data", 32'(bus.sample_data), 32'(m_sample));
    check_eq("fir_coefficient", 32'(bus.fir_coefficient), 32'(m_coef));
    check_eq("strobe_excl", 32'(bus.data_ready & bus.load_coeff), 32'd0);
    bus.modwait = hold || (busy > 0);
  endtask

  task automatic push(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic write_coeff(input logic [1:0] a, input logic [15:0] d);
    bus.coeff_wr    = 1'b1;
    bus.coeff_addr  = a;
    bus.coeff_wdata = d;
    tick();
    bus.coeff_wr = 1'b0;
  endtask

  task automatic pulse_cfg();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_send();
    int start;
    int k;
    start = n_sends;
    k = 0;
    while (n_sends == start && k < 300) begin
      tick();
      k++;
    end
    check_eq("send_seen", 32'(n_sends - start), 32'd1);
  endtask

  task automatic wait_quiet();
    int quiet;
    int k;
    quiet = 0;
    k = 0;
    while (quiet < 4 && k < 3000) begin
      tick();
      k++;
      if (!bus.data_ready && !bus.load_coeff && !bus.modwait &&
          (q.size() == 0 || m_loads < 4)) quiet++;
      else quiet = 0;
    end
    check_eq("quiet_reached", 32'(quiet >= 4), 32'd1);
  endtask

  logic [15:0] exp_coef [4];
  int          s0;
  int          lb;

  initial begin
    rst             = 1'b1;
    bus.coeff_wr    = 1'b0;
    bus.coeff_addr  = 2'd0;
    bus.coeff_wdata = 16'd0;
    bus.cfg_start   = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 16'd0;
    bus.modwait     = 1'b0;
    hold            = 1'b0;
    busy_len        = 0;
    wr_ignored      = 1'b0;
    n_sends         = 0;
    model_reset();

    // reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // 9 pushes with no bank loaded: 8 kept, 9th dropped, nothing sent
    for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i));
    check_eq("full_count", 32'(bus.fifo_count), 32'd8);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("full_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("no_send_without_bank", 32'(n_sends), 32'd0);

    // bank download with a filter busy for 3 cycles after each strobe,
    // then the queued samples drain in order
    exp_coef[0] = 16'h8000;
    exp_coef[1] = 16'hFFFF;
    exp_coef[2] = 16'hFFFF;
    exp_coef[3] = 16'h4000;
    for (int i = 0; i < 4; i++) write_coeff(2'(i), exp_coef[i]);
    busy_len = 3;
    loaded.delete();
    pulse_cfg();
    wait_quiet();
    check_eq("load_count", 32'(loaded.size()), 32'd4);
    for (int i = 0; i < 4 && i < loaded.size(); i++)
      check_eq("load_value", 32'(loaded[i]), 32'(exp_coef[i]));
    check_eq("coeff_ok_set", 32'(bus.coeff_ok), 32'd1);
    check_eq("drained_8", 32'(n_sends), 32'd8);

    // two samples with a slow filter
    busy_len = 10;
    s0 = n_sends;
    push(16'd10);
    push(16'd20);
    wait_quiet();
    check_eq("two_sends", 32'(n_sends - s0), 32'd2);

    // randomized traffic and filter latency
    for (int i = 0; i < 400; i++) begin
      busy_len     = $urandom_range(0, 4);
      bus.in_valid = ($urandom_range(0, 2) == 0);
      bus.in_data  = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_quiet();

    // cfg_start and coeff_wr while waiting on the filter are ignored;
    // push+pop at occupancy 3 leaves the count at 3
    busy_len    = 0;
    hold        = 1'b1;
    bus.modwait = 1'b1;
    push(16'hA5A5);
    wait_send();
    tick();
    tick();
    lb = m_loads;
    wr_ignored      = 1'b1;
    bus.cfg_start   = 1'b1;
    bus.coeff_wr    = 1'b1;
    bus.coeff_addr  = 2'd1;
    bus.coeff_wdata = 16'h1234;
    tick();
    bus.cfg_start = 1'b0;
    bus.coeff_wr  = 1'b0;
    wr_ignored    = 1'b0;
    push(16'h0301);
    push(16'h0302);
    push(16'h0303);
    for (int i = 0; i < 3; i++) tick();
    check_eq("cfg_ignored", 32'(m_loads - lb), 32'd0);
    check_eq("count_3", 32'(bus.fifo_count), 32'd3);
    hold        = 1'b0;
    bus.modwait = (busy > 0);
    tick();
    push(16'h0304);
    check_eq("pushpop_count", 32'(bus.fifo_count), 32'd3);
    check_eq("pushpop_send", 32'(bus.data_ready), 32'd1);
    wait_quiet();
    pulse_cfg();
    wait_quiet();
    check_eq("reload_count", 32'(m_loads - lb), 32'd4);

    // reset in the second SEND cycle aborts the transfer
    busy_len = 2;
    push(16'hBEEF);
    push(16'hCAFE);
    wait_send();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_dr", 32'(bus.data_ready), 32'd0);
    check_eq("abort_sample", 32'(bus.sample_data), 32'd0);
    check_eq("abort_coef", 32'(bus.fir_coefficient), 32'd0);
    check_eq("abort_count", 32'(bus.fifo_count), 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_overflow", 32'(bus.overflow), 32'd0);
    tick();
    check_eq("post_abort_dr", 32'(bus.data_ready), 32'd0);
    check_eq("post_abort_lc", 32'(bus.load_coeff), 32'd0);

    // bank was cleared by reset: download sends zeros, then samples flow
    s0 = n_sends;
    push(16'h0042);
    push(16'h0043);
    for (int i = 0; i < 5; i++) tick();
    check_eq("held_no_bank", 32'(bus.fifo_count), 32'd2);
    pulse_cfg();
    wait_quiet();
    check_eq("final_sends", 32'(n_sends - s0), 32'd2);
    check_eq("final_coeff_ok", 32'(bus.coeff_ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
